// File: rtl/dsb_pkg.sv
// Shared types and helpers for the dSB datapath stages.
//   Q_WIDTH / Q_FRAC : default fixed-point format (Q8.8)
//   q_t              : signed Q-format word
//   acc_state_e      : coupling accumulator FSM states
//   sat_round()      : round-half-up then saturate a wide accumulator to a narrow word
package dsb_pkg;

    localparam int unsigned Q_WIDTH = 16;
    localparam int unsigned Q_FRAC  = 8;

    typedef logic signed [Q_WIDTH-1:0] q_t;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} acc_state_e;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_res_t;

    // acc must already be sign-extended to 64 bits; frac >= 1, width <= 63.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int unsigned        frac,
                                           input int unsigned        width);
        sat_res_t           res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end else begin
            res.sat = 1'b0;
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsb_sat_round.sv
// Combinational round-half-up and saturate from a wide signed accumulator to a WIDTH-bit word.
//   acc_i : signed accumulator, FRAC extra fraction bits relative to the output
//   q_o   : rounded, saturated result
//   sat_o : high when q_o was clipped
module dsb_sat_round
    import dsb_pkg::*;
#(
    parameter int unsigned ACC_W = 36,
    parameter int unsigned WIDTH = Q_WIDTH,
    parameter int unsigned FRAC  = Q_FRAC
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sat_o
);

    logic [63:0] acc_ext;
    sat_res_t    res;
    logic        unused_hi;

    assign acc_ext   = {{(64-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign res       = sat_round(acc_ext, FRAC, WIDTH);
    assign q_o       = res.val[WIDTH-1:0];
    assign sat_o     = res.sat;
    // Upper bits are only a sign extension of q_o after saturation.
    assign unused_hi = ^res.val[63:WIDTH];

endmodule

// File: rtl/dsb_coupling_acc.sv
// Local-field accumulator for one spin node: sums J_ij * x_j over a term group and hands a
// rounded, saturated Q8.8 coupling_force to the downstream PE.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort; flushes pipeline, drops result, clears flags
//   in_valid/in_ready   : term handshake; in_weight, in_x (Q8.8), in_last ends the group
//   out_valid/out_ready : result handshake; coupling_force held while stalled
//   overflow            : sticky, output saturated
//   deg_err             : sticky, a group had more than MAX_DEG terms
// Build option: define DSB_SIGN_COUPLING_EN for discrete-SB mode (x reduced to its sign,
// no multiplier).
module dsb_coupling_acc
    import dsb_pkg::*;
#(
    parameter int unsigned WIDTH   = Q_WIDTH,
    parameter int unsigned FRAC    = Q_FRAC,
    parameter int unsigned MAX_DEG = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_weight,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] coupling_force,
    output logic             overflow,
    output logic             deg_err
);

    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(MAX_DEG) + 1;
    localparam int unsigned CNT_W = $clog2(MAX_DEG + 2);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_DEG + 1);

    acc_state_e state_q;

    logic                 accept;
    logic                 first_term;
    logic [2*WIDTH-1:0]   w_ext;
    logic [2*WIDTH-1:0]   prod_d;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 s1_valid_q;
    logic                 s1_first_q;
    logic                 s1_last_q;
    logic                 s2_last_q;
    logic [ACC_W-1:0]     prod_acc;
    logic [ACC_W-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [WIDTH-1:0]     rnd_val;
    logic                 rnd_sat;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     force_q;
    logic                 overflow_q;
    logic                 deg_err_q;

    assign in_ready   = (state_q == IDLE) || (state_q == ACCUM);
    assign accept     = in_valid && in_ready && !clear;
    assign first_term = (state_q == IDLE);
    assign w_ext      = {{WIDTH{in_weight[WIDTH-1]}}, in_weight};

`ifdef DSB_SIGN_COUPLING_EN
    logic unused_x;
    // Only the sign of x matters; x = 0 counts as +1.
    assign unused_x = ^in_x[WIDTH-2:0];
    always_comb begin
        prod_d = in_x[WIDTH-1] ? ((-w_ext) << FRAC) : (w_ext << FRAC);
    end
`else
    logic [2*WIDTH-1:0] x_ext;
    assign x_ext = {{WIDTH{in_x[WIDTH-1]}}, in_x};
    // Both operands sign-extended to 2*WIDTH, so the truncated product is the signed product.
    always_comb begin
        prod_d = w_ext * x_ext;
    end
`endif

    // Term counter saturates one past MAX_DEG so an over-long group stays detectable.
    always_comb begin
        cnt_d = cnt_q;
        if (first_term) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign prod_acc = {{(ACC_W-2*WIDTH){prod_q[2*WIDTH-1]}}, prod_q};

    // S1 product register, S2 accumulator, term counter and degree flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            deg_err_q  <= 1'b0;
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            deg_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_first_q <= accept && first_term;
            s1_last_q  <= accept && in_last;
            if (accept) begin
                prod_q <= prod_d;
                cnt_q  <= cnt_d;
                if (cnt_d == CntMax) begin
                    deg_err_q <= 1'b1;
                end
            end
            if (s1_valid_q) begin
                acc_q <= s1_first_q ? prod_acc : acc_q + prod_acc;
            end
            // acc_q holds the complete group sum in the cycle this is high.
            s2_last_q <= s1_valid_q && s1_last_q;
        end
    end

    dsb_sat_round #(
        .ACC_W(ACC_W),
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_sat_round (
        .acc_i(acc_q),
        .q_o  (rnd_val),
        .sat_o(rnd_sat)
    );

    // Control FSM with registered result, valid and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            force_q     <= '0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            // The last coupling_force value is deliberately kept.
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s2_last_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        force_q     <= rnd_val;
                        if (rnd_sat) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign coupling_force = force_q;
    assign overflow       = overflow_q;
    assign deg_err        = deg_err_q;

endmodule

// File: tb/tb_dsb_coupling_acc.sv
// Directed self-checking bench for dsb_coupling_acc (default Q8.8, MAX_DEG = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dsb_coupling_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_weight = '0;
    logic [15:0] in_x = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] coupling_force;
    logic        overflow;
    logic        deg_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsb_coupling_acc u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_weight     (in_weight),
        .in_x          (in_x),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .coupling_force(coupling_force),
        .overflow      (overflow),
        .deg_err       (deg_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one term; it is accepted on the following rising edge.
    task automatic term(input logic [15:0] w, input logic [15:0] x, input logic last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_weight = w;
        in_x      = x;
        in_last   = last;
        @(posedge clk);
    endtask

    // Called right after the edge accepting the last term: checks 2-cycle latency and result.
    task automatic finish_group(input string tag, input logic [15:0] exp);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq({tag, "_lat0"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_drain"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_force"}, 32'(coupling_force), 32'(exp));
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_deg"}, 32'(deg_err), 32'd0);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_force", 32'(coupling_force), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_deg", 32'(deg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_rdy", 32'(in_ready), 32'd1);

        // 1.5 - 0.5 = 1.0
        term(16'h0100, 16'h0180, 1'b0);
        term(16'hFF80, 16'h0100, 1'b1);
        finish_group("t1", 16'h0100);
        take_result("t1");

        // Stall the consumer for 5 cycles
        term(16'h0100, 16'h0180, 1'b0);
        term(16'hFF80, 16'h0100, 1'b1);
        finish_group("t3", 16'h0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_hold_force", 32'(coupling_force), 32'h0100);
            check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t3_hold_rdy", 32'(in_ready), 32'd0);
        end
        take_result("t3");

        // Positive and negative saturation
        for (int i = 0; i < 4; i++) term(16'h7FFF, 16'h7FFF, i == 3);
        finish_group("t2p", 16'h7FFF);
        check_eq("t2p_ovf", 32'(overflow), 32'd1);
        take_result("t2p");
        for (int i = 0; i < 4; i++) term(16'h8000, 16'h7FFF, i == 3);
        finish_group("t2n", 16'h8000);
        check_eq("t2n_ovf", 32'(overflow), 32'd1);
        take_result("t2n");
        do_clear("clr1");

        // Nine terms of 0.0625 -> 0.5625, degree error
        for (int i = 0; i < 9; i++) term(16'h0010, 16'h0100, i == 8);
        finish_group("t4", 16'h0090);
        check_eq("t4_deg", 32'(deg_err), 32'd1);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        take_result("t4");
        // Exactly MAX_DEG terms must not be flagged on their own, but the flag is sticky
        for (int i = 0; i < 8; i++) term(16'h0010, 16'h0100, i == 7);
        finish_group("t4b", 16'h0080);
        check_eq("t4b_deg_sticky", 32'(deg_err), 32'd1);
        take_result("t4b");
        do_clear("clr2");
        for (int i = 0; i < 8; i++) term(16'h0010, 16'h0100, i == 7);
        finish_group("t4c", 16'h0080);
        check_eq("t4c_deg", 32'(deg_err), 32'd0);
        take_result("t4c");

        // Abort mid-group; clear wins over a simultaneous last term
        term(16'h0100, 16'h0100, 1'b0);
        term(16'h0100, 16'h0100, 1'b0);
        @(negedge clk);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_weight = 16'h0100;
        in_x      = 16'h0100;
        in_last   = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("t5_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t5_no_valid", 32'(out_valid), 32'd0);
        end
        check_eq("t5_force_kept", 32'(coupling_force), 32'h0080);
        // Single-term group after abort: 2.0 * 0.5 = 1.0 exactly
        term(16'h0200, 16'h0080, 1'b1);
        finish_group("t5", 16'h0100);
        take_result("t5");

        // Sign-mode vector; full multiply gives 1.5/256 - 0.5 = -126.5/256 -> -126/256
        term(16'h0180, 16'h0001, 1'b0);
        term(16'h0100, 16'h0000, 1'b0);
        term(16'h0080, 16'hFF00, 1'b1);
`ifdef DSB_SIGN_COUPLING_EN
        finish_group("t6", 16'h0200);
`else
        finish_group("t6", 16'hFF82);
`endif
        take_result("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
